mdu_sched: RTL and testbench
============================

Name: mdu_sched

Overview:
- Sequencing controller for the multiply/divide unit (MDU) in the E stage of the 5-stage MIPS pipeline.
- Launches mult/multu/div/divu from the E-stage MDU_op code and owns the HI/LO registers.
- Runs the fixed-latency busy window and raises the D-stage stall for any HI/LO-class instruction while the unit is occupied.
- Suppresses launches and HI/LO writes when the CP0 exception/interrupt request flushes the E-stage instruction.

Parameters:
- MULT_LAT, 5, cycles busy stays high after a mult/multu launch (>=1).
- DIV_LAT, 10, cycles busy stays high after a div/divu launch (>=1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- MDU_op  in  5  E-stage MDU operation, `MDU_* codes from const.v; `MDU_err = no operation.
- A  in  32  E-stage forwarded rs value.
- B  in  32  E-stage forwarded rt value.
- req  in  1  CP0 exception/interrupt request; E-stage instruction is being flushed this cycle.
- D_md  in  1  D-stage instruction is mdhilo|mthilo|mfhilo.
- start  out  1  combinational; launch occurs at this clock edge.
- busy  out  1  registered; multi-cycle operation in flight.
- stall  out  1  combinational stall request to the pipeline.
- HI  out  32  registered HI.
- LO  out  32  registered LO.
- MDU_out  out  32  combinational mfhi/mflo read data.

Behaviour:
- Reset: busy=0, cnt=0, HI=0, LO=0, latched operands=0, pending op cleared. Outputs after reset: start=0, stall=0, MDU_out=0 with MDU_op=`MDU_err.
- Reset mid-operation aborts the operation. No HI/LO update.
- start = (MDU_op in {mult,multu,div,divu}) && !busy && !req.
- A launch at edge T does all of the following:
  - latches A, B and the op;
  - loads cnt = MULT_LAT or DIV_LAT;
  - sets busy=1 from T+1.
- While busy, cnt decrements each edge.
- At the edge where cnt==1:
  - HI/LO are written with the result;
  - busy clears, cnt goes to 0;
  - the new values are visible in the cycle after that edge.
- busy is therefore high for exactly MULT_LAT or DIV_LAT cycles.
- Mult/div issued while busy: the MDU_op is ignored with no effect. This is illegal upstream because the stall prevents it.
- req asserted while busy does not cancel the in-flight operation. The operation was already committed.
- Arithmetic results:
  - mult: {HI,LO} = signed 64-bit A*B.
  - multu: {HI,LO} = unsigned 64-bit A*B.
  - div: LO = quotient, HI = remainder; signed, truncated toward zero; remainder takes the sign of the dividend.
  - divu: unsigned quotient and remainder.
- Division boundaries:
  - Divide by zero (div or divu): HI and LO unchanged, but the busy window still runs the full DIV_LAT.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- mthi/mtlo write A into HI/LO at the edge, only when !busy && !req. Otherwise the write is dropped. Upstream stall guarantees !busy.
- MDU_out = HI for `MDU_mfhi, LO for `MDU_mflo, 0 otherwise. It returns current register values, never in-flight results.
- stall = D_md && (busy || start).
  - It covers the launch cycle, because busy is not yet high then.
  - It does not assert on the completion cycle's successor. D-stage mfhi then reaches E after the HI/LO write.
- A pure stall condition never modifies HI/LO.

Test Plan:
- Reset then idle → busy=0, HI=LO=0, stall=0, start=0, MDU_out=0.
- mult A=0xFFFFFFFE (-2), B=3 at edge T → busy high T+1..T+5. At edge T+5: HI=0xFFFFFFFF, LO=0xFFFFFFFA. Same operands as multu → HI=0x00000002, LO=0xFFFFFFFA.
- div A=0xFFFFFFF9 (-7), B=2 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. div by B=0 with HI=0x11, LO=0x22 beforehand → unchanged after 10 busy cycles.
- Launch div with D_md=1 held → stall=1 in launch cycle and all 10 busy cycles, then 0. Mfhi issued after the stall reads the new HI on MDU_out.
- mult with req=1 in the same cycle → start=0, busy stays 0, HI/LO unchanged. mtlo A=0x1234 with req=1 → LO unchanged. With req=0 → LO=0x1234 next cycle.
- reset asserted at busy cycle 3 of a mult → next cycle busy=0, HI=LO=0, no late write.

Source files
------------

// File: rtl/mdu_sched_if.sv
// -----------------------------------------------------------------------------
// mdu_pkg / mdu_sched_if
//   mdu_pkg      : encoding of the E-stage MDU operation code.
//   mdu_sched_if : pipeline <-> MDU sequencer bundle.
//     master (pipeline side) drives MDU_op, A, B, req, D_md and observes
//                            start, busy, stall, HI, LO, MDU_out.
//     slave  (MDU side)      is the mirror image.
// -----------------------------------------------------------------------------
package mdu_pkg;

  typedef enum logic [4:0] {
    MDU_ERR   = 5'd0,   // no MDU operation
    MDU_MULT  = 5'd1,
    MDU_MULTU = 5'd2,
    MDU_DIV   = 5'd3,
    MDU_DIVU  = 5'd4,
    MDU_MFHI  = 5'd5,
    MDU_MFLO  = 5'd6,
    MDU_MTHI  = 5'd7,
    MDU_MTLO  = 5'd8
  } mdu_op_e;

endpackage

interface mdu_sched_if;

  logic [4:0]  MDU_op;   // E-stage MDU operation
  logic [31:0] A;        // forwarded rs
  logic [31:0] B;        // forwarded rt
  logic        req;      // CP0 flush of the E-stage instruction
  logic        D_md;     // D-stage instruction touches HI/LO
  logic        start;    // launch happens at this edge
  logic        busy;     // multi-cycle operation in flight
  logic        stall;    // stall request to the pipeline
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDU_out;  // mfhi/mflo read data

  modport master (
    output MDU_op, A, B, req, D_md,
    input  start, busy, stall, HI, LO, MDU_out
  );

  modport slave (
    input  MDU_op, A, B, req, D_md,
    output start, busy, stall, HI, LO, MDU_out
  );

endinterface

// File: rtl/mdu_sched.sv
// -----------------------------------------------------------------------------
// mdu_sched
//   Sequencing controller for the E-stage multiply/divide unit. Launches
//   mult/multu/div/divu, runs a fixed-latency busy window, owns HI/LO and
//   stalls HI/LO-class instructions in D while the unit is occupied.
//
// Ports:
//   clk    : clock, all state changes on the rising edge
//   reset  : synchronous active-high reset
//   bus    : mdu_sched_if.slave (operation, operands, flush, D-stage hint,
//            start/busy/stall status, HI/LO and mfhi/mflo read data)
//
// Parameters:
//   MULT_LAT : busy cycles after a mult/multu launch (>= 1)
//   DIV_LAT  : busy cycles after a div/divu launch   (>= 1)
// -----------------------------------------------------------------------------
module mdu_sched
  import mdu_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  mdu_sched_if.slave  bus
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [4:0]         op_q,    op_d;
  logic [31:0]        a_q,     a_d;
  logic [31:0]        b_q,     b_d;
  logic [31:0]        hi_q,    hi_d;
  logic [31:0]        lo_q,    lo_d;

  logic               is_arith;
  logic               is_mult_op;
  logic               start;

  logic signed [63:0] a_sx;
  logic signed [63:0] b_sx;
  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic               div_zero;
  logic               div_ovf;
  logic [31:0]        quot_s, rem_s;
  logic [31:0]        quot_u, rem_u;

  // ---------------------------------------------------------------------------
  // Launch decode
  // ---------------------------------------------------------------------------
  assign is_arith   = (bus.MDU_op == MDU_MULT) || (bus.MDU_op == MDU_MULTU) ||
                      (bus.MDU_op == MDU_DIV)  || (bus.MDU_op == MDU_DIVU);
  assign is_mult_op = (bus.MDU_op == MDU_MULT) || (bus.MDU_op == MDU_MULTU);
  assign start      = is_arith && (state_q == ST_IDLE) && !bus.req;

  // ---------------------------------------------------------------------------
  // Arithmetic on the latched operands; only sampled at the completion edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    a_sx     = {{32{a_q[31]}}, a_q};
    b_sx     = {{32{b_q[31]}}, b_q};
    prod_s   = a_sx * b_sx;
    prod_u   = {32'd0, a_q} * {32'd0, b_q};
    div_zero = (b_q == 32'd0);
    // Most-negative / -1 overflows the signed quotient; define it explicitly
    // rather than relying on how the divider wraps.
    div_ovf  = (a_q == 32'h8000_0000) && (b_q == 32'hFFFF_FFFF);
    quot_s   = 32'd0;
    rem_s    = 32'd0;
    quot_u   = 32'd0;
    rem_u    = 32'd0;
    if (!div_zero) begin
      quot_u = a_q / b_q;
      rem_u  = a_q % b_q;
      if (div_ovf) begin
        quot_s = 32'h8000_0000;
        rem_s  = 32'd0;
      end else begin
        quot_s = $signed(a_q) / $signed(b_q);
        rem_s  = $signed(a_q) % $signed(b_q);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case/if tree leaves one unassigned (which would infer a latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = bus.MDU_op;
          a_d     = bus.A;
          b_d     = bus.B;
          cnt_d   = is_mult_op ? CNT_W'(MULT_LAT) : CNT_W'(DIV_LAT);
          state_d = ST_BUSY;
        end else if (!bus.req) begin
          // Moves to HI/LO are only honoured when the unit is idle and the
          // instruction is not being flushed.
          if (bus.MDU_op == MDU_MTHI) hi_d = bus.A;
          if (bus.MDU_op == MDU_MTLO) lo_d = bus.A;
        end
      end

      ST_BUSY: begin
        // Any MDU_op arriving here is ignored: upstream stall keeps it away,
        // and a flush cannot cancel an already committed operation.
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          unique case (op_q)
            MDU_MULT:  {hi_d, lo_d} = prod_s;
            MDU_MULTU: {hi_d, lo_d} = prod_u;
            MDU_DIV: begin
              if (!div_zero) begin
                lo_d = quot_s;
                hi_d = rem_s;
              end
            end
            MDU_DIVU: begin
              if (!div_zero) begin
                lo_d = quot_u;
                hi_d = rem_u;
              end
            end
            default: ;
          endcase
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge
    // value of every other flop, independent of statement order.
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= MDU_ERR;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.start   = start;
  assign bus.busy    = (state_q == ST_BUSY);
  // The launch cycle is covered by start, since busy only rises afterwards.
  assign bus.stall   = bus.D_md && ((state_q == ST_BUSY) || start);
  assign bus.HI      = hi_q;
  assign bus.LO      = lo_q;
  assign bus.MDU_out = (bus.MDU_op == MDU_MFHI) ? hi_q :
                       (bus.MDU_op == MDU_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_mdu_sched.sv
// -----------------------------------------------------------------------------
// tb_mdu_sched
//   Self-checking bench for mdu_sched. Inputs change on the falling edge;
//   outputs are observed shortly after, away from the rising edge. Expected
//   HI/LO come from an arithmetic model of the instruction semantics.
// -----------------------------------------------------------------------------
module tb_mdu_sched;
  import mdu_pkg::*;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  logic [31:0] exp_hi;
  logic [31:0] exp_lo;

  mdu_sched_if bus ();

  mdu_sched #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: instruction semantics in plain arithmetic.
  // ---------------------------------------------------------------------------
  function automatic void mdu_model(input logic [4:0] op,
                                    input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] hi, output logic [31:0] lo,
                                    output bit wr);
    longint      ps;
    logic [63:0] pu;
    logic [63:0] pbits;
    logic [31:0] ma, mb, q, r;
    hi = 32'd0;
    lo = 32'd0;
    wr = 1'b0;
    case (op)
      MDU_MULT: begin
        ps    = longint'(signed'(a)) * longint'(signed'(b));
        pbits = ps;
        hi    = pbits[63:32];
        lo    = pbits[31:0];
        wr    = 1'b1;
      end
      MDU_MULTU: begin
        pu = {32'd0, a} * {32'd0, b};
        hi = pu[63:32];
        lo = pu[31:0];
        wr = 1'b1;
      end
      MDU_DIV: begin
        if (b != 32'd0) begin
          ma = a[31] ? (32'd0 - a) : a;
          mb = b[31] ? (32'd0 - b) : b;
          q  = ma / mb;
          r  = ma % mb;
          if (a[31] ^ b[31]) q = 32'd0 - q;
          if (a[31])         r = 32'd0 - r;
          lo = q;
          hi = r;
          wr = 1'b1;
        end
      end
      MDU_DIVU: begin
        if (b != 32'd0) begin
          lo = a / b;
          hi = a % b;
          wr = 1'b1;
        end
      end
      default: ;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.MDU_op = MDU_ERR;
    bus.A      = 32'd0;
    bus.B      = 32'd0;
    bus.req    = 1'b0;
    bus.D_md   = 1'b0;
  endtask

  // Launch one arithmetic op and check the whole busy window and the result.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] nh, nl;
    bit          wr;
    int          lat;
    mdu_model(op, a, b, nh, nl, wr);
    lat = (op == MDU_MULT || op == MDU_MULTU) ? MULT_LAT : DIV_LAT;
    bus.MDU_op = op;
    bus.A      = a;
    bus.B      = b;
    #1;
    checks++;
    if (bus.start !== 1'b1) begin
      failures++;
      $display("FAIL launch_start op=%0d got=%b exp=1", op, bus.start);
    end
    checks++;
    if (bus.stall !== bus.D_md) begin
      failures++;
      $display("FAIL launch_stall op=%0d got=%b exp=%b", op, bus.stall, bus.D_md);
    end
    step();
    // Scramble the operand inputs to prove the launch latched them.
    bus.MDU_op = MDU_ERR;
    bus.A      = $urandom;
    bus.B      = $urandom;
    #1;
    for (int i = 0; i < lat; i++) begin
      checks++;
      if (bus.busy !== 1'b1 || bus.HI !== exp_hi || bus.LO !== exp_lo ||
          bus.stall !== bus.D_md) begin
        failures++;
        $display("FAIL busy_window op=%0d cyc=%0d busy=%b hi=%h lo=%h stall=%b exp busy=1 hi=%h lo=%h stall=%b",
                 op, i, bus.busy, bus.HI, bus.LO, bus.stall, exp_hi, exp_lo, bus.D_md);
      end
      step();
    end
    if (wr) begin
      exp_hi = nh;
      exp_lo = nl;
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.stall !== 1'b0 || bus.HI !== exp_hi || bus.LO !== exp_lo) begin
      failures++;
      $display("FAIL result op=%0d a=%h b=%h busy=%b stall=%b hi=%h lo=%h exp busy=0 stall=0 hi=%h lo=%h",
               op, a, b, bus.busy, bus.stall, bus.HI, bus.LO, exp_hi, exp_lo);
    end
  endtask

  // mthi/mtlo with an optional flush; checks the register a cycle later.
  task automatic move_to(input logic [4:0] op, input logic [31:0] a, input logic flush);
    bus.MDU_op = op;
    bus.A      = a;
    bus.req    = flush;
    step();
    bus.MDU_op = MDU_ERR;
    bus.req    = 1'b0;
    #1;
    if (!flush) begin
      if (op == MDU_MTHI) exp_hi = a;
      if (op == MDU_MTLO) exp_lo = a;
    end
    checks++;
    if (bus.HI !== exp_hi || bus.LO !== exp_lo) begin
      failures++;
      $display("FAIL move op=%0d req=%b hi=%h lo=%h exp hi=%h lo=%h",
               op, flush, bus.HI, bus.LO, exp_hi, exp_lo);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.start !== 1'b0 || bus.stall !== 1'b0 ||
        bus.HI !== 32'd0 || bus.LO !== 32'd0 || bus.MDU_out !== 32'd0) begin
      failures++;
      $display("FAIL reset_state busy=%b start=%b stall=%b hi=%h lo=%h out=%h exp all zero",
               bus.busy, bus.start, bus.stall, bus.HI, bus.LO, bus.MDU_out);
    end
  endtask

  task automatic test_mult();
    run_op(MDU_MULT, 32'hFFFF_FFFE, 32'd3);
    checks++;
    if (bus.HI !== 32'hFFFF_FFFF || bus.LO !== 32'hFFFF_FFFA) begin
      failures++;
      $display("FAIL mult_neg2x3 hi=%h lo=%h exp hi=ffffffff lo=fffffffa", bus.HI, bus.LO);
    end
    run_op(MDU_MULTU, 32'hFFFF_FFFE, 32'd3);
    checks++;
    if (bus.HI !== 32'h0000_0002 || bus.LO !== 32'hFFFF_FFFA) begin
      failures++;
      $display("FAIL multu_fffffffex3 hi=%h lo=%h exp hi=00000002 lo=fffffffa", bus.HI, bus.LO);
    end
  endtask

  task automatic test_div();
    run_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2);
    checks++;
    if (bus.HI !== 32'hFFFF_FFFF || bus.LO !== 32'hFFFF_FFFD) begin
      failures++;
      $display("FAIL div_neg7by2 hi=%h lo=%h exp hi=ffffffff lo=fffffffd", bus.HI, bus.LO);
    end
    run_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    checks++;
    if (bus.HI !== 32'd0 || bus.LO !== 32'h8000_0000) begin
      failures++;
      $display("FAIL div_overflow hi=%h lo=%h exp hi=00000000 lo=80000000", bus.HI, bus.LO);
    end
    run_op(MDU_DIVU, 32'hFFFF_FFF9, 32'd2);
    move_to(MDU_MTHI, 32'h11, 1'b0);
    move_to(MDU_MTLO, 32'h22, 1'b0);
    run_op(MDU_DIV, 32'h1234_5678, 32'd0);
    run_op(MDU_DIVU, 32'h1234_5678, 32'd0);
    checks++;
    if (bus.HI !== 32'h11 || bus.LO !== 32'h22) begin
      failures++;
      $display("FAIL div_by_zero hi=%h lo=%h exp hi=00000011 lo=00000022", bus.HI, bus.LO);
    end
  endtask

  task automatic test_stall();
    bus.D_md = 1'b1;
    run_op(MDU_DIV, 32'd1000, 32'hFFFF_FFF9);
    bus.MDU_op = MDU_MFHI;
    #1;
    checks++;
    if (bus.MDU_out !== exp_hi || bus.stall !== 1'b0) begin
      failures++;
      $display("FAIL mfhi_after_stall out=%h stall=%b exp out=%h stall=0", bus.MDU_out, bus.stall, exp_hi);
    end
    bus.MDU_op = MDU_MFLO;
    #1;
    checks++;
    if (bus.MDU_out !== exp_lo) begin
      failures++;
      $display("FAIL mflo_read out=%h exp=%h", bus.MDU_out, exp_lo);
    end
    bus.MDU_op = MDU_ERR;
    bus.D_md   = 1'b0;
  endtask

  task automatic test_req();
    logic [31:0] hi0, lo0;
    hi0 = exp_hi;
    lo0 = exp_lo;
    bus.MDU_op = MDU_MULT;
    bus.A      = 32'd7;
    bus.B      = 32'd9;
    bus.req    = 1'b1;
    #1;
    checks++;
    if (bus.start !== 1'b0) begin
      failures++;
      $display("FAIL req_start got=%b exp=0", bus.start);
    end
    step();
    bus.MDU_op = MDU_ERR;
    bus.req    = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.HI !== hi0 || bus.LO !== lo0) begin
      failures++;
      $display("FAIL req_no_launch busy=%b hi=%h lo=%h exp busy=0 hi=%h lo=%h",
               bus.busy, bus.HI, bus.LO, hi0, lo0);
    end
    move_to(MDU_MTLO, 32'h1234, 1'b1);
    move_to(MDU_MTLO, 32'h1234, 1'b0);
    checks++;
    if (bus.LO !== 32'h1234) begin
      failures++;
      $display("FAIL mtlo_value lo=%h exp=00001234", bus.LO);
    end
  endtask

  // Ops presented while busy (including a flush) must not disturb the window.
  task automatic test_busy_ignore();
    bus.MDU_op = MDU_DIVU;
    bus.A      = 32'd100;
    bus.B      = 32'd7;
    step();
    for (int i = 0; i < DIV_LAT; i++) begin
      case (i)
        1:       begin bus.MDU_op = MDU_MULT; bus.A = 32'd5;  bus.B = 32'd5; end
        3:       begin bus.MDU_op = MDU_MTHI; bus.A = 32'hDEAD; end
        5:       begin bus.MDU_op = MDU_DIV;  bus.req = 1'b1; end
        default: begin bus.MDU_op = MDU_ERR;  bus.req = 1'b0; end
      endcase
      #1;
      checks++;
      if (bus.start !== 1'b0 || bus.busy !== 1'b1) begin
        failures++;
        $display("FAIL busy_ignore cyc=%0d start=%b busy=%b exp start=0 busy=1", i, bus.start, bus.busy);
      end
      step();
    end
    bus.MDU_op = MDU_ERR;
    bus.req    = 1'b0;
    exp_hi     = 32'd2;
    exp_lo     = 32'd14;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.HI !== exp_hi || bus.LO !== exp_lo) begin
      failures++;
      $display("FAIL busy_ignore_result busy=%b hi=%h lo=%h exp busy=0 hi=%h lo=%h",
               bus.busy, bus.HI, bus.LO, exp_hi, exp_lo);
    end
  endtask

  task automatic test_reset_mid();
    bus.MDU_op = MDU_MULT;
    bus.A      = 32'h0001_0003;
    bus.B      = 32'h0002_0005;
    step();
    bus.MDU_op = MDU_ERR;
    step();
    step();
    reset = 1'b1;
    step();
    reset  = 1'b0;
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.HI !== 32'd0 || bus.LO !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid busy=%b hi=%h lo=%h exp busy=0 hi=0 lo=0", bus.busy, bus.HI, bus.LO);
    end
    for (int i = 0; i < MULT_LAT + 2; i++) step();
    checks++;
    if (bus.busy !== 1'b0 || bus.HI !== 32'd0 || bus.LO !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid_late busy=%b hi=%h lo=%h exp busy=0 hi=0 lo=0", bus.busy, bus.HI, bus.LO);
    end
  endtask

  task automatic test_random();
    logic [4:0]  op;
    logic [31:0] a, b;
    for (int n = 0; n < 30; n++) begin
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom);
      if ($urandom_range(0, 3) == 0) b = {28'd0, 4'($urandom)};
      bus.D_md = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       op = MDU_MULT;
        1:       op = MDU_MULTU;
        2:       op = MDU_DIV;
        3:       op = MDU_DIVU;
        4:       op = MDU_MTHI;
        default: op = MDU_MTLO;
      endcase
      if (op == MDU_MTHI || op == MDU_MTLO)
        move_to(op, a, 1'($urandom_range(0, 1)));
      else
        run_op(op, a, b);
    end
    bus.D_md = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    exp_hi   = 32'd0;
    exp_lo   = 32'd0;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_mult();
    test_div();
    test_stall();
    test_req();
    test_busy_ignore();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
